// File: rtl/btn_pkg.sv
// Shared types and helpers for the debounced push-button reader.
package btn_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } btn_state_e;

  // Bits needed to hold the values 0..val inclusive.
  function automatic int unsigned cnt_width(input int unsigned val);
    return $clog2(val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button pin bundle: raw pins in, debounced level and event pulses out.
interface btn_debounce_if #(
  parameter int unsigned N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;

  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, long_pulse
  );
endinterface

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-FF synchroniser, debounce FSM, hold counter and
// registered level/press/release/long-press outputs.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic clk100,
  input  logic clr_n,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

  logic          r_sync1, r_sync2;
  btn_state_e    r_state, w_state_nx;
  logic [DW-1:0] r_stable, w_stable_nx;
  logic [HW-1:0] r_hold, w_hold_nx, w_hold_inc;
  logic          r_from_long, w_from_long_nx;
  logic          r_level, w_level_nx;
  logic          r_press, w_press_nx;
  logic          r_release, w_release_nx;
  logic          r_long, w_long_nx;

  always_ff @(posedge clk100 or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= RELEASED;
      r_stable    <= '0;
      r_hold      <= '0;
      r_from_long <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_sync1     <= i_btn_raw;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nx;
      r_stable    <= w_stable_nx;
      r_hold      <= w_hold_nx;
      r_from_long <= w_from_long_nx;
      r_level     <= w_level_nx;
      r_press     <= w_press_nx;
      r_release   <= w_release_nx;
      r_long      <= w_long_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_stable_nx    = r_stable;
    w_hold_nx      = r_hold;
    w_from_long_nx = r_from_long;
    w_level_nx     = r_level;
    w_press_nx     = 1'b0;
    w_release_nx   = 1'b0;
    w_long_nx      = 1'b0;
    w_hold_inc     = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;

    case (r_state)
      RELEASED: begin
        if (r_sync2) begin
          w_state_nx  = PRESS_WAIT;
          w_stable_nx = DEB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nx  = RELEASED;
          w_stable_nx = '0;
        end else if (r_stable == DEB_MAX) begin
          w_state_nx  = PRESSED;
          w_stable_nx = '0;
          w_hold_nx   = '0;
          w_level_nx  = 1'b1;
          w_press_nx  = 1'b1;
        end else begin
          w_stable_nx = r_stable + 1'b1;
        end
      end
      PRESSED: begin
        w_hold_nx = w_hold_inc;
        if (!r_sync2) begin
          w_state_nx     = RELEASE_WAIT;
          w_stable_nx    = DEB_ONE;
          w_from_long_nx = 1'b0;
        end else if (r_hold >= HOLD_FIRE) begin
          w_state_nx = LONG_HELD;
          w_long_nx  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!r_sync2) begin
          w_state_nx     = RELEASE_WAIT;
          w_stable_nx    = DEB_ONE;
          w_from_long_nx = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // Hold time keeps accruing through a release bounce so a recovered
        // press still fires long_pulse on its original schedule.
        if (!r_from_long) w_hold_nx = w_hold_inc;
        if (r_sync2) begin
          w_state_nx  = r_from_long ? LONG_HELD : PRESSED;
          w_stable_nx = '0;
        end else if (r_stable == DEB_MAX) begin
          w_state_nx   = RELEASED;
          w_stable_nx  = '0;
          w_hold_nx    = '0;
          w_level_nx   = 1'b0;
          w_release_nx = 1'b1;
        end else begin
          w_stable_nx = r_stable + 1'b1;
        end
      end
      default: w_state_nx = RELEASED;
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

// File: rtl/btn_debounce.sv
// Debounced push-button reader: N_BTN independent channels, each with its
// own synchroniser, debounce FSM and event pulses.
module btn_debounce #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input logic           clk100,
  input logic           clr_n,
  btn_debounce_if.slave bus
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk100    (clk100),
      .clr_n     (clr_n),
      .i_btn_raw (bus.btn_raw[g]),
      .o_level   (bus.btn_level[g]),
      .o_press   (bus.press_pulse[g]),
      .o_release (bus.release_pulse[g]),
      .o_long    (bus.long_pulse[g])
    );
  end

endmodule
